fp_add_pipe: RTL and testbench
==============================

# fp_add_pipe

Parametrised, three-stage pipelined floating-point adder/subtractor, the successor to the team's combinational 12-bit FP adder. Operand format is generalised to sign | EXP_W-bit biased exponent | MAN_W-bit fraction with hidden 1. The block adds round-to-nearest-even, special-value handling and status flags. A valid/ready handshake with full backpressure lets it sit between the operand-issue logic and the result buffer.

## Interface
- EXP_W, 4, exponent width; bias = 2^(EXP_W-1)-1
- MAN_W, 7, stored fraction width (hidden bit not stored)
- W = 1+EXP_W+MAN_W (derived, 12 by default; not overridable)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand beat offered
- in_ready  out  1  block accepts beat this cycle
- x  in  W  operand A
- y  in  W  operand B
- sub  in  1  1: A-B, 0: A+B
- out_valid  out  1  result beat offered
- out_ready  in  1  consumer accepts result
- result  out  W  rounded sum
- ovf  out  1  result overflowed to infinity
- unf  out  1  nonzero exact result flushed to zero
- inv  out  1  invalid operation (inf-inf, NaN input)

## Operation
- Encoding:
  - exponent 0 = zero (fraction ignored; no denormals, flush-to-zero);
  - exponent all-ones with fraction 0 = ±inf;
  - exponent all-ones with fraction ≠0 = NaN.
  - Canonical NaN output = 0 | all-ones exp | 1 followed by zeros.
- Stage 1 (align):
  - effective B sign = y sign XOR sub;
  - compare {exp,frac} magnitudes and swap so that P holds the larger;
  - shift Q right by the exponent difference into a MAN_W+4-bit field (hidden, fraction, guard, round, sticky);
  - shifts ≥ MAN_W+3 leave sticky only;
  - decode special cases and carry them alongside.
- Stage 2 (add): add or subtract the aligned mantissas at MAN_W+5 bits, giving a carry-out bit; the result sign is P's sign.
- Stage 3 (normalise/round/pack):
  - carry-out: shift right 1, fold the shifted bit into sticky, exp+1;
  - otherwise: leading-zero count, then shift left with exp decremented;
  - RNE on guard/round/sticky; a rounding carry renormalises.
- Exceptions:
  - exp ≥ all-ones → ±inf, ovf=1;
  - exp ≤ 0 with nonzero sum → +0, unf=1;
  - exact cancellation → +0, except (-0)+(-0) → -0.
- Specials:
  - any NaN → canonical NaN, inv=1;
  - inf ± inf with opposite effective signs → canonical NaN, inv=1;
  - inf with any other operand → that inf, no flags;
  - zero + B → B exactly (sign adjusted by sub).
- Flags are per-beat and travel with their result.

## Timing
- Latency: 3 cycles from an accepted input beat to out_valid, with no stalls.
- Throughput: 1 beat/cycle.
- Handshake:
  - advance = out_ready | ~out_valid;
  - all three stages shift together on advance;
  - in_ready = advance (combinational from out_ready);
  - a beat transfers when valid & ready on the same edge.
- Stall: while out_valid & ~out_ready, result and flags are held stable and no stage updates. An in_valid offered during a stall is not taken.
- Bubbles: stage valid bits propagate empty slots; out_valid is never asserted for a bubble.
- Reset: async on rst_n low; all stage valids, out_valid, result, ovf, unf and inv go to 0 immediately. Beats in flight are discarded. in_ready is 1 once out_valid=0.

## Test plan
- 0x380+0x380 (1.0+1.0), sub=0 → 0x400 at cycle +3; 0x400+0x380 → 0x440 (3.0); no flags.
- 0x380 with sub=1 against 0x380 → 0x000; 0xB80+0x380 (-1.0+1.0) → 0x000 (+0).
- Rounding: 0x580+0x180 (16+2^-4, tie) → 0x580; 0x580+0x240 (16+1.5 ulp) → 0x582.
- 0x77F+0x77F → 0x780, ovf=1; 0x780 with sub=1 against 0x780 → 0x7C0, inv=1; 0x088-0x080 → 0x000, unf=1.
- Back-to-back 8 beats with out_ready toggling 1,0,0,1: results emerge in order, none lost or duplicated, and output is held stable during stalls.
- Assert rst_n low with 3 beats in flight: outputs go to 0 immediately, no stale beat appears after release, and a fresh beat gives a correct result 3 cycles later.
- Repeat rounding and overflow checks with EXP_W=5, MAN_W=10 against a reference model.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined floating-point adder/subtractor.
// Operand format is sign | biased exponent | fraction with a hidden 1.
// Denormals are flushed to zero and results use round-to-nearest-even.
// Stage 1 aligns the operands, stage 2 adds them, and stage 3 normalises,
// rounds and packs the result. All stages advance together under a
// valid/ready handshake.
module fp_add_pipe #(
  parameter  int EXP_W = 4,
  parameter  int MAN_W = 7,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         unf,
  output logic         inv
);

  localparam int FW  = MAN_W + 4;        // aligned field: hidden, fraction, guard, round, sticky
  localparam int SW  = MAN_W + 5;        // sum field with carry-out
  localparam int LZW = $clog2(SW);
  localparam int EW  = EXP_W + 2;        // signed working exponent
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // ---------------- stage 1: decode, swap, align ----------------
  logic             xs, ys_eff, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, swap;
  logic [EXP_W-1:0] xe, ye, p_e, q_e, dexp;
  logic [MAN_W-1:0] xf, yf, p_f, q_f;
  logic             p_s;
  logic [FW-1:0]    q_al;
  logic [2*FW-1:0]  q_ext;
  logic             spec_c, spec_inv_c;
  logic [W-1:0]     spec_res_c;

  logic             s1_valid, s1_sign, s1_eff_sub, s1_spec, s1_spec_inv;
  logic [EXP_W-1:0] s1_exp;
  logic [FW-1:0]    s1_mp, s1_mq;
  logic [W-1:0]     s1_spec_res;

  // Unpack operands, order them by magnitude, shift the smaller and decode specials
  always_comb begin
    xs     = x[W-1];
    xe     = x[W-2:MAN_W];
    xf     = x[MAN_W-1:0];
    ys_eff = y[W-1] ^ sub;
    ye     = y[W-2:MAN_W];
    yf     = y[MAN_W-1:0];
    x_zero = (xe == '0);
    y_zero = (ye == '0);
    x_inf  = (xe == EMAX) && (xf == '0);
    y_inf  = (ye == EMAX) && (yf == '0);
    x_nan  = (xe == EMAX) && (xf != '0);
    y_nan  = (ye == EMAX) && (yf != '0);

    swap = {ye, yf} > {xe, xf};
    p_s  = swap ? ys_eff : xs;
    p_e  = swap ? ye : xe;
    p_f  = swap ? yf : xf;
    q_e  = swap ? xe : ye;
    q_f  = swap ? xf : yf;
    dexp = p_e - q_e;

    // Bits shifted past the field collapse into the sticky position
    q_ext = {1'b1, q_f, 3'b000, {FW{1'b0}}} >> dexp;
    if (32'(dexp) >= MAN_W + 3)
      q_al = {{(FW-1){1'b0}}, 1'b1};
    else
      q_al = q_ext[2*FW-1:FW] | {{(FW-1){1'b0}}, |q_ext[FW-1:0]};

    spec_c     = 1'b1;
    spec_inv_c = 1'b0;
    spec_res_c = '0;
    if (x_nan || y_nan) begin
      spec_res_c = QNAN;
      spec_inv_c = 1'b1;
    end else if (x_inf && y_inf && (xs != ys_eff)) begin
      spec_res_c = QNAN;
      spec_inv_c = 1'b1;
    end else if (x_inf) begin
      spec_res_c = x;
    end else if (y_inf) begin
      spec_res_c = {ys_eff, y[W-2:0]};
    end else if (x_zero && y_zero) begin
      spec_res_c = {xs & ys_eff, {(W-1){1'b0}}};
    end else if (x_zero) begin
      spec_res_c = {ys_eff, y[W-2:0]};
    end else if (y_zero) begin
      spec_res_c = x;
    end else begin
      spec_c = 1'b0;
    end
  end

  // Stage 1 register: aligned mantissas plus the decoded special result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_eff_sub  <= 1'b0;
      s1_exp      <= '0;
      s1_mp       <= '0;
      s1_mq       <= '0;
      s1_spec     <= 1'b0;
      s1_spec_inv <= 1'b0;
      s1_spec_res <= '0;
    end else if (advance) begin
      s1_valid    <= in_valid;
      s1_sign     <= p_s;
      s1_eff_sub  <= xs ^ ys_eff;
      s1_exp      <= p_e;
      s1_mp       <= {1'b1, p_f, 3'b000};
      s1_mq       <= q_al;
      s1_spec     <= spec_c;
      s1_spec_inv <= spec_inv_c;
      s1_spec_res <= spec_res_c;
    end
  end

  // ---------------- stage 2: add / subtract ----------------
  logic [SW-1:0]    sum_c;
  logic             s2_valid, s2_sign, s2_spec, s2_spec_inv;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sum;
  logic [W-1:0]     s2_spec_res;

  // P is never smaller than Q, so the difference cannot go negative
  always_comb begin
    if (s1_eff_sub)
      sum_c = {1'b0, s1_mp} - {1'b0, s1_mq};
    else
      sum_c = {1'b0, s1_mp} + {1'b0, s1_mq};
  end

  // Stage 2 register: raw sum with its exponent, sign and special info
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_exp      <= '0;
      s2_sum      <= '0;
      s2_spec     <= 1'b0;
      s2_spec_inv <= 1'b0;
      s2_spec_res <= '0;
    end else if (advance) begin
      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum_c;
      s2_spec     <= s1_spec;
      s2_spec_inv <= s1_spec_inv;
      s2_spec_res <= s1_spec_res;
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [LZW-1:0]   lzc;
  logic [FW-1:0]    norm;
  logic [EW-1:0]    exp_n, exp_r;
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac_r;
  logic             rnd, rc;
  logic [W-1:0]     res_c;
  logic             ovf_c, unf_c, inv_c;

  // Normalise the sum, apply round-to-nearest-even, then range-check the exponent
  always_comb begin
    lzc = '0;
    for (int i = 0; i < SW - 1; i++) begin
      if (s2_sum[i]) lzc = LZW'(SW - 2 - i);
    end

    if (s2_sum[SW-1]) begin
      norm  = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
      exp_n = {2'b00, s2_exp} + {{(EW-1){1'b0}}, 1'b1};
    end else begin
      norm  = s2_sum[SW-2:0] << lzc;
      exp_n = {2'b00, s2_exp} - {{(EW-LZW){1'b0}}, lzc};
    end

    mant   = norm[FW-1:3];
    rnd    = norm[2] & (norm[1] | norm[0] | mant[0]);
    mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd};
    rc     = mant_r[MAN_W+1];
    exp_r  = exp_n + {{(EW-1){1'b0}}, rc};
    frac_r = rc ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

    res_c = '0;
    ovf_c = 1'b0;
    unf_c = 1'b0;
    inv_c = 1'b0;
    if (s2_spec) begin
      res_c = s2_spec_res;
      inv_c = s2_spec_inv;
    end else if (s2_sum == '0) begin
      res_c = '0;
    end else if (!exp_r[EW-1] && (exp_r[EW-2:0] >= {1'b0, EMAX})) begin
      res_c = {s2_sign, EMAX, {MAN_W{1'b0}}};
      ovf_c = 1'b1;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      res_c = '0;
      unf_c = 1'b1;
    end else begin
      res_c = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    end
  end

  // Output register: result and flags held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      inv       <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      result    <= res_c;
      ovf       <= ovf_c;
      unf       <= unf_c;
      inv       <= inv_c;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: two instances (4/7 and 5/10 formats) share the
// handshake; a driver pushes expected results into queues and a monitor
// pops and compares them whenever a result beat transfers.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] xa = '0, ya = '0;
  logic [15:0] xb = '0, yb = '0;
  logic        in_ready_a, in_ready_b, ova, ovb;
  logic [11:0] res_a;
  logic [15:0] res_b;
  logic        ovf_a, unf_a, inv_a, ovf_b, unf_b, inv_b;

  int n_cmp = 0;
  int n_bad = 0;
  int ready_mode = 0;
  logic [14:0] qa[$];
  logic [18:0] qb[$];

  always #5 clk = ~clk;

  fp_add_pipe #(.EXP_W(4), .MAN_W(7)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .x(xa), .y(ya), .sub(sub), .out_valid(ova), .out_ready(out_ready),
    .result(res_a), .ovf(ovf_a), .unf(unf_a), .inv(inv_a));

  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .x(xb), .y(yb), .sub(sub), .out_valid(ovb), .out_ready(out_ready),
    .result(res_b), .ovf(ovf_b), .unf(unf_b), .inv(inv_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Reference: decode to reals, add exactly, round the real sum to MAN_W+1 bits
  function automatic logic [18:0] ref_add(input int ew, input int mw,
                                          input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
    int bias = (1 << (ew - 1)) - 1;
    int emax = (1 << ew) - 1;
    int fmask = (1 << mw) - 1;
    int xs = int'(x >> (ew + mw)) & 1;
    int ys = (int'(y >> (ew + mw)) & 1) ^ int'(s);
    int xe = int'(x >> mw) & emax;
    int ye = int'(y >> mw) & emax;
    int xf = int'(x) & fmask;
    int yf = int'(y) & fmask;
    int qnan = (emax << mw) | (1 << (mw - 1));
    int smask = (1 << (ew + mw)) - 1;
    int r, e, fl, be;
    logic o = 1'b0, u = 1'b0, iv = 1'b0;
    real vx, vy, v, a, m, fr;
    if ((xe == emax && xf != 0) || (ye == emax && yf != 0)) begin
      r = qnan; iv = 1'b1;
    end else if (xe == emax && ye == emax && xs != ys) begin
      r = qnan; iv = 1'b1;
    end else if (xe == emax) begin
      r = int'(x);
    end else if (ye == emax) begin
      r = (ys << (ew + mw)) | (int'(y) & smask);
    end else if (xe == 0 && ye == 0) begin
      r = (xs & ys) << (ew + mw);
    end else if (xe == 0) begin
      r = (ys << (ew + mw)) | (int'(y) & smask);
    end else if (ye == 0) begin
      r = int'(x);
    end else begin
      vx = (1.0 + real'(xf) * p2(-mw)) * p2(xe - bias);
      vy = (1.0 + real'(yf) * p2(-mw)) * p2(ye - bias);
      if (xs == 1) vx = -vx;
      if (ys == 1) vy = -vy;
      v = vx + vy;
      if (v == 0.0) begin
        r = 0;
      end else begin
        a = (v < 0.0) ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m  = a * p2(mw);
        fl = $rtoi(m);
        fr = m - real'(fl);
        if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
        if (fl == (1 << (mw + 1))) begin fl = fl >> 1; e++; end
        be = e + bias;
        if (be >= emax) begin
          r = ((v < 0.0 ? 1 : 0) << (ew + mw)) | (emax << mw); o = 1'b1;
        end else if (be <= 0) begin
          r = 0; u = 1'b1;
        end else begin
          r = ((v < 0.0 ? 1 : 0) << (ew + mw)) | (be << mw) | (fl - (1 << mw));
        end
      end
    end
    return {iv, u, o, 16'(r)};
  endfunction

  // Offer one beat; the expected results are queued once in_ready shows it will transfer
  task automatic send(input logic [11:0] a, input logic [11:0] b,
                      input logic [15:0] c, input logic [15:0] d, input logic s,
                      input logic use_exp, input logic [14:0] expa);
    int waitc = 0;
    logic done = 1'b0;
    logic [18:0] ma;
    @(negedge clk); #1;
    in_valid = 1'b1; xa = a; ya = b; xb = c; yb = d; sub = s;
    while (!done) begin
      #1;
      if (in_ready_a) begin
        ma = ref_add(4, 7, {4'b0, a}, {4'b0, b}, s);
        qa.push_back(use_exp ? expa : {ma[18:16], ma[11:0]});
        qb.push_back(ref_add(5, 10, c, d, s));
        done = 1'b1;
        @(posedge clk);
      end else begin
        waitc++;
        if (waitc > 200) begin
          n_cmp++; n_bad++;
          $display("FAIL accept_timeout: in_ready %b required 1", in_ready_a);
          in_valid = 1'b0;
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; in_valid = 1'b0; end
  endtask

  task automatic drain();
    int c = 0;
    idle(1);
    while ((qa.size() != 0 || qb.size() != 0) && c < 300) begin @(negedge clk); c++; end
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
  endtask

  task automatic rnd_op(input int ew, input int mw, output logic [15:0] a, output logic [15:0] b);
    int emax = (1 << ew) - 1;
    int ea, eb, fa, fb, sel;
    sel = int'($urandom_range(0, 19));
    ea = (sel == 0) ? 0 : (sel == 1) ? emax : int'($urandom_range(1, emax - 1));
    sel = int'($urandom_range(0, 19));
    if (sel == 0) eb = 0;
    else if (sel == 1) eb = emax;
    else if (sel < 14) begin
      eb = ea + int'($urandom_range(0, 6)) - 3;
      if (eb < 1) eb = 1;
      if (eb > emax - 1) eb = emax - 1;
    end else eb = int'($urandom_range(1, emax - 1));
    fa = int'($urandom) & ((1 << mw) - 1);
    fb = int'($urandom) & ((1 << mw) - 1);
    if (ea == emax && $urandom_range(0, 1) == 1) fa = 0;
    if (eb == emax && $urandom_range(0, 1) == 1) fb = 0;
    a = 16'((int'($urandom_range(0, 1)) << (ew + mw)) | (ea << mw) | fa);
    b = 16'((int'($urandom_range(0, 1)) << (ew + mw)) | (eb << mw) | fb);
    if ($urandom_range(0, 9) == 0) b = a;
  endtask

  // Consumer ready: 0 always, 1 pattern 1,0,0,1, 2 random, 3 never
  initial begin
    int rc = 0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (rc % 4 == 0) || (rc % 4 == 3);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      rc++;
    end
  end

  // Monitor: compare transferring beats and check stability across stalls
  initial begin
    logic stall = 1'b0;
    logic [15:0] held_a;
    logic [19:0] held_b;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_a", {ova, inv_a, unf_a, ovf_a, res_a}, held_a);
          chk("hold_b", {ovb, inv_b, unf_b, ovf_b, res_b}, held_b);
        end
        if (ova && out_ready) begin
          if (qa.size() == 0) chk("unexpected_a", 32'(ova), 0);
          else chk("res_a", {inv_a, unf_a, ovf_a, res_a}, qa.pop_front());
        end
        if (ovb && out_ready) begin
          if (qb.size() == 0) chk("unexpected_b", 32'(ovb), 0);
          else chk("res_b", {inv_b, unf_b, ovf_b, res_b}, qb.pop_front());
        end
        stall  = ova && !out_ready;
        held_a = {ova, inv_a, unf_a, ovf_a, res_a};
        held_b = {ovb, inv_b, unf_b, ovf_b, res_b};
      end
    end
  end

  typedef struct {
    logic [11:0] a, b;
    logic        s;
    logic [14:0] e;
    logic [15:0] c, d;
  } vec_t;

  vec_t dir[9] = '{
    '{12'h380, 12'h380, 1'b0, 15'h0400, 16'h3C00, 16'h3C00},
    '{12'h400, 12'h380, 1'b0, 15'h0440, 16'h4000, 16'h3C00},
    '{12'h380, 12'h380, 1'b1, 15'h0000, 16'h3C00, 16'h3C00},
    '{12'hB80, 12'h380, 1'b0, 15'h0000, 16'hBC00, 16'h3C00},
    '{12'h580, 12'h180, 1'b0, 15'h0580, 16'h4C00, 16'h2000},
    '{12'h580, 12'h240, 1'b0, 15'h0582, 16'h4C00, 16'h2600},
    '{12'h77F, 12'h77F, 1'b0, 15'h1780, 16'h7BFF, 16'h7BFF},
    '{12'h780, 12'h780, 1'b1, 15'h47C0, 16'h7C00, 16'h7C00},
    '{12'h088, 12'h080, 1'b1, 15'h2000, 16'h0440, 16'h0400}
  };

  task automatic latency_check(input string nm);
    int lat = 0;
    send(12'h380, 12'h380, 16'h3C00, 16'h3C00, 1'b0, 1'b1, 15'h0400);
    idle(0);
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) begin @(negedge clk); #1; in_valid = 1'b0; #2; end
      else begin @(negedge clk); #3; end
      if (ova) begin lat = k; break; end
    end
    chk(nm, lat, 3);
  endtask

  initial begin
    logic [15:0] a, b, c, d;
    logic s;
    ready_mode = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_valid", {ova, ovb}, 0);
    chk("rst_res_a", {inv_a, unf_a, ovf_a, res_a}, 0);
    chk("rst_res_b", {inv_b, unf_b, ovf_b, res_b}, 0);
    chk("rst_in_ready", {in_ready_a, in_ready_b}, 2'b11);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      send(dir[i].a, dir[i].b, dir[i].c, dir[i].d, dir[i].s, 1'b1, dir[i].e);
    drain();
    latency_check("latency");
    drain();

    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      rnd_op(4, 7, a, b);
      rnd_op(5, 10, c, d);
      send(a[11:0], b[11:0], c, d, s, 1'b0, '0);
    end
    drain();

    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom_range(0, 1));
      rnd_op(4, 7, a, b);
      rnd_op(5, 10, c, d);
      send(a[11:0], b[11:0], c, d, s, 1'b0, '0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    ready_mode = 0;
    drain();

    // Fill the pipe with three beats that cannot leave, then reset mid-flight
    ready_mode = 3;
    for (int i = 0; i < 3; i++) send(dir[i].a, dir[i].b, dir[i].c, dir[i].d, dir[i].s, 1'b1, dir[i].e);
    idle(1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {ova, ovb, inv_a, unf_a, ovf_a, res_a}, 0);
    chk("mid_rst_res_b", {inv_b, unf_b, ovf_b, res_b}, 0);
    chk("mid_rst_in_ready", {in_ready_a, in_ready_b}, 2'b11);
    qa.delete();
    qb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #3;
      chk("stale", {ova, ovb}, 0);
    end
    latency_check("latency_after_rst");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
